token_scheduler: RTL

Queue controller for the token dispenser path. Issues sequential customer tokens numbered 1..7 (wrapping), holds up to 7 waiting tokens in FIFO order, and hands them to two service counters through a round-robin arbiter. Its `waiting` output is the count driven into the token display generator, so the display always shows exactly the tokens currently queued.

---
 rtl/token_scheduler.sv | 92 +++++++++
 1 files changed

// File: rtl/token_scheduler.sv
// token_scheduler: issues wrapping tokens 1..MAX_TOKENS into a FIFO and hands them to two counters by round-robin
// Ports: clk, rst (sync, active-high); issue_req -> issue_ack/issue_token; call_req/done per counter ->
//        call_grant/call_token; serving0/serving1 token held at each counter (0 = idle);
//        waiting/full/empty queue occupancy
module token_scheduler #(
    parameter int unsigned MAX_TOKENS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_req,
    output logic       issue_ack,
    output logic [3:0] issue_token,
    input  logic [1:0] call_req,
    input  logic [1:0] done,
    output logic [1:0] call_grant,
    output logic [3:0] call_token,
    output logic [3:0] serving0,
    output logic [3:0] serving1,
    output logic [3:0] waiting,
    output logic       full,
    output logic       empty
);
    localparam logic [3:0] MAX = 4'(MAX_TOKENS);
    typedef enum logic {IDLE, SERVING} state_e;
    state_e     state_q [2];
    state_e     state_d [2];
    logic [3:0] serving_q [2];
    logic [3:0] serving_d [2];
    logic [3:0] head_q, head_d, next_q, next_d, count_q, count_d;
    logic [3:0] issue_token_d, call_token_d;
    logic [1:0] call_grant_d, elig;
    logic       prio_q, prio_d, issue_ack_d, do_issue, do_grant;
    function automatic logic [3:0] inc(input logic [3:0] v);
        return v == MAX ? 4'd1 : v + 4'd1;
    endfunction
    // Tokens are issued in strict sequence, so head and count fully describe the queue contents.
    assign waiting  = count_q;
    assign full     = count_q == MAX;
    assign empty    = count_q == 4'd0;
    assign serving0 = serving_q[0];
    assign serving1 = serving_q[1];
    always_comb begin
        elig = '0;
        for (int c = 0; c < 2; c++) elig[c] = state_q[c] == IDLE && call_req[c] && !empty;
        call_grant_d  = &elig ? (prio_q ? 2'b10 : 2'b01) : elig;
        do_grant      = |call_grant_d;
        do_issue      = issue_req && !full;
        issue_ack_d   = do_issue;
        issue_token_d = do_issue ? next_q : 4'd0;
        call_token_d  = do_grant ? head_q : 4'd0;
        next_d        = do_issue ? inc(next_q) : next_q;
        head_d        = do_grant ? inc(head_q) : head_q;
        count_d       = count_q + 4'(do_issue) - 4'(do_grant);
        prio_d        = do_grant ? call_grant_d[0] : prio_q;
        for (int c = 0; c < 2; c++) begin
            state_d[c]   = state_q[c];
            serving_d[c] = serving_q[c];
            if (call_grant_d[c]) begin
                state_d[c]   = SERVING;
                serving_d[c] = head_q;
            end else if (state_q[c] == SERVING && done[c]) begin
                state_d[c]   = IDLE;
                serving_d[c] = 4'd0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= '{default: IDLE};
            serving_q   <= '{default: 4'd0};
            head_q      <= 4'd1;
            next_q      <= 4'd1;
            count_q     <= 4'd0;
            prio_q      <= 1'b0;
            issue_ack   <= 1'b0;
            issue_token <= 4'd0;
            call_grant  <= 2'b00;
            call_token  <= 4'd0;
        end else begin
            state_q     <= state_d;
            serving_q   <= serving_d;
            head_q      <= head_d;
            next_q      <= next_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
            issue_ack   <= issue_ack_d;
            issue_token <= issue_token_d;
            call_grant  <= call_grant_d;
            call_token  <= call_token_d;
        end
    end
endmodule
